// File: rtl/dispatch_queue_arb.sv
// Instruction queue feeding a one-per-cycle dispatch arbiter with round-robin RS choice and ROB tags.
// Optional DISPATCH_STATS_EN adds saturating stall/dispatch counters.
module dispatch_queue_arb #(
   parameter int QDEPTH       = 4,
   parameter int NUM_CLASSES  = 4,
   parameter int RS_PER_CLASS = 2,
   parameter int ROB_SIZE     = 16,
   parameter int CLW          = 2,
   localparam int TAGW        = $clog2(ROB_SIZE),
   localparam int NRS         = NUM_CLASSES * RS_PER_CLASS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [TAGW-1:0]   flush_tag,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CLW-1:0]    in_class,
   input  logic [6:0]        in_op,
   input  logic [4:0]        in_dest,
   input  logic [4:0]        in_src1,
   input  logic [4:0]        in_src2,
   input  logic              rob_full,
   input  logic [NRS-1:0]    rs_full,
   output logic [NRS-1:0]    rs_load,
   output logic              disp_valid,
   output logic [6:0]        disp_op,
   output logic [4:0]        disp_dest,
   output logic [4:0]        disp_src1,
   output logic [4:0]        disp_src2,
   output logic [TAGW-1:0]   disp_tag,
   output logic              disp_dest_we,
   output logic              disp_illegal
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]       stat_rob_stall,
   output logic [31:0]       stat_rs_stall,
   output logic [31:0]       stat_dispatched
`endif
);

   localparam int QW  = $clog2(QDEPTH);
   localparam int RPW = (RS_PER_CLASS > 1) ? $clog2(RS_PER_CLASS) : 1;

   logic [QW-1:0]   head_q, head_d, tail_q, tail_d;
   logic [QW:0]     count_q, count_d;
   logic [TAGW-1:0] tag_q, tag_d;
   logic [RPW-1:0]  rr_q [NUM_CLASSES];
   logic [RPW-1:0]  rr_d [NUM_CLASSES];

   logic [CLW-1:0]  cls_mem [QDEPTH];
   logic [6:0]      op_mem  [QDEPTH];
   logic [4:0]      dst_mem [QDEPTH];
   logic [4:0]      s1_mem  [QDEPTH];
   logic [4:0]      s2_mem  [QDEPTH];

   logic                    h_legal, h_found, enq, deq;
   logic [RS_PER_CLASS-1:0] cls_full;
   int                      cidx, h_ptr, h_sel;

   // Head-entry arbitration: pick the first non-full RS starting at the class pointer.
   always_comb begin
      h_legal  = int'(cls_mem[head_q]) < NUM_CLASSES;
      cidx     = h_legal ? int'(cls_mem[head_q]) : 0;
      h_ptr    = 0;
      cls_full = '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         if (c == cidx) begin
            h_ptr = int'(rr_q[c]);
            for (int k = 0; k < RS_PER_CLASS; k++) cls_full[k] = rs_full[c*RS_PER_CLASS + k];
         end
      end
      h_found = 1'b0;
      h_sel   = 0;
      for (int i = 0; i < RS_PER_CLASS; i++) begin
         for (int k = 0; k < RS_PER_CLASS; k++) begin
            if (h_legal && !h_found && k == (h_ptr + i) % RS_PER_CLASS && !cls_full[k]) begin
               h_found = 1'b1;
               h_sel   = k;
            end
         end
      end
      in_ready = (int'(count_q) < QDEPTH) && !flush;
      enq      = in_valid && in_ready;
      deq      = (count_q != '0) && !rob_full && !flush && (!h_legal || h_found);
   end

   always_comb begin
      rs_load = '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
         for (int k = 0; k < RS_PER_CLASS; k++) begin
            if (deq && h_legal && c == cidx && k == h_sel) rs_load[c*RS_PER_CLASS + k] = 1'b1;
         end
      end
      disp_valid   = deq;
      disp_op      = deq ? op_mem[head_q] : '0;
      disp_dest    = deq ? dst_mem[head_q] : '0;
      disp_src1    = deq ? s1_mem[head_q] : '0;
      disp_src2    = deq ? s2_mem[head_q] : '0;
      disp_tag     = deq ? tag_q : '0;
      disp_dest_we = deq && (dst_mem[head_q] != 5'd0);
      disp_illegal = deq && !h_legal;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      tag_d   = tag_q;
      rr_d    = rr_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         tag_d   = flush_tag;
         for (int c = 0; c < NUM_CLASSES; c++) rr_d[c] = '0;
      end else begin
         if (enq) tail_d = tail_q + 1'b1;
         if (deq) begin
            head_d = head_q + 1'b1;
            tag_d  = tag_q + 1'b1;
         end
         if (enq && !deq) count_d = count_q + 1'b1;
         else if (!enq && deq) count_d = count_q - 1'b1;
         for (int c = 0; c < NUM_CLASSES; c++) begin
            if (deq && h_legal && c == cidx) rr_d[c] = RPW'((h_sel + 1) % RS_PER_CLASS);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         tag_q   <= '0;
         for (int c = 0; c < NUM_CLASSES; c++) rr_q[c] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         tag_q   <= tag_d;
         rr_q    <= rr_d;
      end
   end

   // Payload storage carries no reset; occupancy is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (enq) begin
         cls_mem[tail_q] <= in_class;
         op_mem[tail_q]  <= in_op;
         dst_mem[tail_q] <= in_dest;
         s1_mem[tail_q]  <= in_src1;
         s2_mem[tail_q]  <= in_src2;
      end
   end

`ifdef DISPATCH_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

   logic [31:0] rob_stall_q, rs_stall_q, dispatched_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rob_stall_q  <= '0;
         rs_stall_q   <= '0;
         dispatched_q <= '0;
      end else begin
         if (count_q != '0 && rob_full) rob_stall_q <= sat_inc(rob_stall_q);
         if (count_q != '0 && !rob_full && h_legal && !h_found) rs_stall_q <= sat_inc(rs_stall_q);
         if (deq) dispatched_q <= sat_inc(dispatched_q);
      end
   end

   assign stat_rob_stall  = rob_stall_q;
   assign stat_rs_stall   = rs_stall_q;
   assign stat_dispatched = dispatched_q;
`endif

endmodule
